// File: rtl/i2c_word_arbiter.sv
// -----------------------------------------------------------------------------
// i2c_word_arbiter
//
// Shares one I2C write-word engine (slave address + pointer + data byte,
// GO/END_OK handshake) between two requesters. For example, VCM focus writes
// use requester 0 and sensor register configuration uses requester 1.
//
// Each transaction runs as follows:
//   1. Round-robin grant.
//   2. Latch the 24-bit word onto the engine inputs.
//   3. Pulse the active-low GO.
//   4. Wait for END_OK.
//   5. Pulse the requester ACK.
//   6. Hold off for an inter-transaction bus gap.
//
// Runs entirely on the I2C tick clock.
//
// Parameters
//   GO_LOW_CYC   cycles ENG_GO_N is held low per launch (1..255)
//   GO_SETTLE    cycles after GO_N release before ENG_END is looked at (1..255)
//   GAP_CYC      idle cycles between transactions (0 = none, up to 2^20-1)
//   TIMEOUT_CYC  watchdog limit in cycles (only with I2C_ARB_TIMEOUT_EN)
//
// Build option
//   I2C_ARB_TIMEOUT_EN  when defined, a watchdog started at GO_LOW entry forces
//                       completion of a hung transaction and sets the sticky
//                       ERR flag. When undefined, WAIT_END waits forever and
//                       ERR is tied low.
//
// Ports
//   CLK_400K      in   1   I2C tick clock
//   RESET_N       in   1   asynchronous active-low reset
//   REQ0 / REQ1   in   1   request level, held until matching ACK
//   WORD0 / WORD1 in   24  {slave[7:0], pointer[7:0], data[7:0]}
//   ACK0 / ACK1   out  1   one-cycle pulse: transaction finished
//   ENG_GO_N      out  1   engine launch, active low
//   ENG_SLAVE     out  8   engine slave address
//   ENG_POINTER   out  8   engine register pointer
//   ENG_WDATA     out  8   engine write data
//   ENG_END       in   1   engine END_OK, 1 = idle/done
//   BUSY          out  1   high in every state except IDLE
//   GNT_ID        out  1   requester currently or last served
//   ERR           out  1   sticky watchdog flag
// -----------------------------------------------------------------------------
// state     | meaning
// ----------+------------------------------------------------------------------
// IDLE      | waiting for a request while the engine reports done
// LOAD      | latch granted word, update grant/last-served, drop GO_N
// GO_LOW    | hold GO_N low for GO_LOW_CYC cycles in total
// SETTLE    | ignore ENG_END for GO_SETTLE cycles (stale done from engine)
// WAIT_END  | wait for ENG_END (or watchdog expiry when built in)
// DONE      | one-cycle ACK to the granted requester
// GAP       | enforced bus idle for GAP_CYC cycles
// -----------------------------------------------------------------------------
module i2c_word_arbiter #(
   parameter int unsigned GO_LOW_CYC  = 3,
   parameter int unsigned GO_SETTLE   = 2,
   parameter int unsigned GAP_CYC     = 1000,
   parameter int unsigned TIMEOUT_CYC = 4096
) (
   input  logic        CLK_400K,
   input  logic        RESET_N,
   input  logic        REQ0,
   input  logic        REQ1,
   input  logic [23:0] WORD0,
   input  logic [23:0] WORD1,
   output logic        ACK0,
   output logic        ACK1,
   output logic        ENG_GO_N,
   output logic [7:0]  ENG_SLAVE,
   output logic [7:0]  ENG_POINTER,
   output logic [7:0]  ENG_WDATA,
   input  logic        ENG_END,
   output logic        BUSY,
   output logic        GNT_ID,
   output logic        ERR
);

   // Reject parameter values outside the supported ranges at elaboration.
   if (GO_LOW_CYC < 1 || GO_LOW_CYC > 255 || GO_SETTLE < 1 || GO_SETTLE > 255 ||
       GAP_CYC > 1048575 || TIMEOUT_CYC < 1) begin : g_bad_param
      $error("i2c_word_arbiter: parameter out of range");
   end

   // One down-counter is shared by GO_LOW, SETTLE and GAP.
   // It is sized for the largest of the three.
   localparam int unsigned CNT_MAX_A = (GO_LOW_CYC > GO_SETTLE) ? GO_LOW_CYC : GO_SETTLE;
   localparam int unsigned CNT_MAX   = (GAP_CYC > CNT_MAX_A) ? GAP_CYC : CNT_MAX_A;
   localparam int          CNT_W     = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] GO_LOW_LOAD = CNT_W'(GO_LOW_CYC - 1);
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(GO_SETTLE - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_GO_LOW,
      ST_SETTLE,
      ST_WAIT_END,
      ST_DONE,
      ST_GAP
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             go_n_q, go_n_d;
   logic [23:0]      word_q, word_d;
   logic             ack0_q, ack0_d;
   logic             ack1_q, ack1_d;
   logic             gnt_id_q, gnt_id_d;
   logic             last_q, last_d;
   logic             sel_q, sel_d;

`ifdef I2C_ARB_TIMEOUT_EN
   localparam int                WD_W   = $clog2(TIMEOUT_CYC + 1);
   localparam logic [WD_W-1:0]   WD_MAX = WD_W'(TIMEOUT_CYC);
   localparam logic [WD_W-1:0]   WD_LIM = WD_W'(TIMEOUT_CYC - 1);

   logic [WD_W-1:0] wd_q, wd_d;
   logic            err_q, err_d;
`endif

   always_ff @(posedge CLK_400K or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         go_n_q   <= 1'b1;
         word_q   <= '0;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         gnt_id_q <= 1'b0;
         last_q   <= 1'b1;
         sel_q    <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
         wd_q     <= '0;
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         go_n_q   <= go_n_d;
         word_q   <= word_d;
         ack0_q   <= ack0_d;
         ack1_q   <= ack1_d;
         gnt_id_q <= gnt_id_d;
         last_q   <= last_d;
         sel_q    <= sel_d;
`ifdef I2C_ARB_TIMEOUT_EN
         wd_q     <= wd_d;
         err_q    <= err_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      go_n_d   = go_n_q;
      word_d   = word_q;
      ack0_d   = 1'b0;
      ack1_d   = 1'b0;
      gnt_id_d = gnt_id_q;
      last_d   = last_q;
      sel_d    = sel_q;
`ifdef I2C_ARB_TIMEOUT_EN
      wd_d     = wd_q;
      err_d    = err_q;
      // The watchdog only advances while a launch is outstanding.
      // It saturates at the limit instead of wrapping.
      if ((state_q == ST_GO_LOW || state_q == ST_SETTLE || state_q == ST_WAIT_END) &&
          wd_q != WD_MAX) begin
         wd_d = wd_q + 1'b1;
      end
`endif

      case (state_q)
         ST_IDLE: begin
            if ((REQ0 | REQ1) && ENG_END) begin
               state_d = ST_LOAD;
               // With both requesting, serve whoever was not served last.
               if (REQ0 && REQ1) sel_d = ~last_q;
               else              sel_d = REQ1;
            end
         end

         ST_LOAD: begin
            word_d   = sel_q ? WORD1 : WORD0;
            gnt_id_d = sel_q;
            last_d   = sel_q;
            go_n_d   = 1'b0;
            cnt_d    = GO_LOW_LOAD;
            state_d  = ST_GO_LOW;
`ifdef I2C_ARB_TIMEOUT_EN
            wd_d     = '0;
`endif
         end

         ST_GO_LOW: begin
            if (cnt_q == '0) begin
               go_n_d  = 1'b1;
               cnt_d   = SETTLE_LOAD;
               state_d = ST_SETTLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         ST_SETTLE: begin
            if (cnt_q == '0) state_d = ST_WAIT_END;
            else             cnt_d   = cnt_q - 1'b1;
         end

         ST_WAIT_END: begin
            if (ENG_END) begin
               state_d = ST_DONE;
               ack0_d  = ~gnt_id_q;
               ack1_d  = gnt_id_q;
            end
`ifdef I2C_ARB_TIMEOUT_EN
            else if (wd_q >= WD_LIM) begin
               // Engine hung: flag it but still ACK so the requester never stalls.
               err_d   = 1'b1;
               go_n_d  = 1'b1;
               state_d = ST_DONE;
               ack0_d  = ~gnt_id_q;
               ack1_d  = gnt_id_q;
            end
`endif
         end

         ST_DONE: begin
            if (GAP_CYC == 0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d   = GAP_LOAD;
               state_d = ST_GAP;
            end
         end

         ST_GAP: begin
            if (cnt_q == '0) state_d = ST_IDLE;
            else             cnt_d   = cnt_q - 1'b1;
         end

         default: begin
            state_d = ST_IDLE;
            go_n_d  = 1'b1;
         end
      endcase
   end

   assign ACK0        = ack0_q;
   assign ACK1        = ack1_q;
   assign ENG_GO_N    = go_n_q;
   assign ENG_SLAVE   = word_q[23:16];
   assign ENG_POINTER = word_q[15:8];
   assign ENG_WDATA   = word_q[7:0];
   assign BUSY        = (state_q != ST_IDLE);
   assign GNT_ID      = gnt_id_q;

`ifdef I2C_ARB_TIMEOUT_EN
   assign ERR = err_q;
`else
   assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_word_arbiter.sv
module tb_i2c_word_arbiter;

   localparam int unsigned GO_LOW_CYC  = 3;
   localparam int unsigned GO_SETTLE   = 2;
   localparam int unsigned GAP_CYC     = 20;
   localparam int unsigned TIMEOUT_CYC = 64;

   logic        CLK_400K;
   logic        RESET_N;
   logic        REQ0, REQ1;
   logic [23:0] WORD0, WORD1;
   logic        ACK0, ACK1;
   logic        ENG_GO_N;
   logic [7:0]  ENG_SLAVE, ENG_POINTER, ENG_WDATA;
   logic        ENG_END;
   logic        BUSY, GNT_ID, ERR;

   logic        eng_done;
   logic        eng_ok;
   int          eng_cnt;

   int total = 0;
   int bad   = 0;

   i2c_word_arbiter #(
      .GO_LOW_CYC  (GO_LOW_CYC),
      .GO_SETTLE   (GO_SETTLE),
      .GAP_CYC     (GAP_CYC),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .CLK_400K    (CLK_400K),
      .RESET_N     (RESET_N),
      .REQ0        (REQ0),
      .REQ1        (REQ1),
      .WORD0       (WORD0),
      .WORD1       (WORD1),
      .ACK0        (ACK0),
      .ACK1        (ACK1),
      .ENG_GO_N    (ENG_GO_N),
      .ENG_SLAVE   (ENG_SLAVE),
      .ENG_POINTER (ENG_POINTER),
      .ENG_WDATA   (ENG_WDATA),
      .ENG_END     (ENG_END),
      .BUSY        (BUSY),
      .GNT_ID      (GNT_ID),
      .ERR         (ERR)
   );

   initial begin
      CLK_400K = 1'b0;
      forever #5 CLK_400K = ~CLK_400K;
   end

   // Engine model: drops END while GO_N is low, reports done 10 cycles after release.
   assign ENG_END = eng_done & eng_ok;

   initial begin
      eng_done = 1'b1;
      eng_cnt  = 0;
      forever begin
         @(negedge CLK_400K);
         if (ENG_GO_N === 1'b0) begin
            eng_done = 1'b0;
            eng_cnt  = 10;
         end else if (eng_cnt > 0) begin
            eng_cnt = eng_cnt - 1;
            if (eng_cnt == 0) eng_done = 1'b1;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish in time");
      $fatal(1, "global timeout");
   end

   task automatic tick();
      @(posedge CLK_400K);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_go_low(input string tag, input int budget);
      int n;
      n = 0;
      while (ENG_GO_N !== 1'b0 && n < budget) begin
         tick();
         n++;
      end
      chk(tag, {31'd0, ENG_GO_N}, 32'd0);
   endtask

   task automatic wait_ack(input string tag, input int budget, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!(ACK0 === 1'b1 || ACK1 === 1'b1) && n < budget);
      chk(tag, {31'd0, (ACK0 | ACK1)}, 32'd1);
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n;
      n = 0;
      while (BUSY !== 1'b0 && n < budget) begin
         tick();
         n++;
      end
      chk(tag, {31'd0, BUSY}, 32'd0);
   endtask

   initial begin
      int  n;
      bit  stable;

      RESET_N = 1'b0;
      REQ0    = 1'b0;
      REQ1    = 1'b0;
      WORD0   = '0;
      WORD1   = '0;
      eng_ok  = 1'b1;
      repeat (3) tick();

      // Reset values
      chk("rst_go_n",  {31'd0, ENG_GO_N}, 32'd1);
      chk("rst_busy",  {31'd0, BUSY},     32'd0);
      chk("rst_ack",   {30'd0, ACK1, ACK0}, 32'd0);
      chk("rst_gnt",   {31'd0, GNT_ID},   32'd0);
      chk("rst_err",   {31'd0, ERR},      32'd0);
      chk("rst_word",  {8'd0, ENG_SLAVE, ENG_POINTER, ENG_WDATA}, 32'd0);

      // Test 1: single request from requester 0
      REQ0  = 1'b1;
      WORD0 = 24'h18_03_A5;
      @(negedge CLK_400K);
      RESET_N = 1'b1;
      tick();
      chk("t1_load_busy", {31'd0, BUSY},     32'd1);
      chk("t1_load_go_n", {31'd0, ENG_GO_N}, 32'd1);
      tick();
      chk("t1_go_low0", {31'd0, ENG_GO_N}, 32'd0);
      chk("t1_word",    {8'd0, ENG_SLAVE, ENG_POINTER, ENG_WDATA}, 32'h0018_03A5);
      chk("t1_gnt",     {31'd0, GNT_ID},   32'd0);
      tick();
      chk("t1_go_low1", {31'd0, ENG_GO_N}, 32'd0);
      tick();
      chk("t1_go_low2", {31'd0, ENG_GO_N}, 32'd0);
      tick();
      chk("t1_go_rel",  {31'd0, ENG_GO_N}, 32'd1);
      wait_ack("t1_ack_seen", 50, n);
      chk("t1_ack_lat",  n, 32'd10);
      chk("t1_ack_id",   {30'd0, ACK1, ACK0}, 32'd1);
      REQ0 = 1'b0;
      tick();
      chk("t1_ack_pulse", {30'd0, ACK1, ACK0}, 32'd0);
      chk("t1_gap_busy",  {31'd0, BUSY}, 32'd1);
      repeat (GAP_CYC - 1) tick();
      chk("t1_gap_end_busy", {31'd0, BUSY}, 32'd1);
      tick();
      chk("t1_idle", {31'd0, BUSY}, 32'd0);

      // Test 2: contention straight out of reset alternates 0,1,0,1
      RESET_N = 1'b0;
      tick();
      REQ0  = 1'b1;
      REQ1  = 1'b1;
      WORD0 = 24'h11_22_33;
      WORD1 = 24'h44_55_66;
      @(negedge CLK_400K);
      RESET_N = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wait_ack("t2_ack_seen", 100, n);
         chk("t2_ack_order", {30'd0, ACK1, ACK0}, (k % 2 == 0) ? 32'd1 : 32'd2);
         chk("t2_gnt",       {31'd0, GNT_ID},     (k % 2 == 0) ? 32'd0 : 32'd1);
         chk("t2_ack_spacing", n, (k == 0) ? 32'd15 : 32'd36);
         if (k == 3) begin
            REQ0 = 1'b0;
            REQ1 = 1'b0;
         end
      end
      wait_idle("t2_idle", 100);

      // Test 3: engine busy while idle blocks the launch
      eng_ok = 1'b0;
      REQ1   = 1'b1;
      WORD1  = 24'h20_10_5A;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("t3_held_busy", {31'd0, BUSY}, 32'd0);
      end
      chk("t3_held_go_n", {31'd0, ENG_GO_N}, 32'd1);
      eng_ok = 1'b1;
      tick();
      chk("t3_load_busy", {31'd0, BUSY}, 32'd1);
      tick();
      chk("t3_go_low", {31'd0, ENG_GO_N}, 32'd0);
      chk("t3_word",   {8'd0, ENG_SLAVE, ENG_POINTER, ENG_WDATA}, 32'h0020_105A);
      chk("t3_gnt",    {31'd0, GNT_ID}, 32'd1);
      REQ1 = 1'b0;
      wait_ack("t3_ack_seen", 50, n);
      chk("t3_ack_id", {30'd0, ACK1, ACK0}, 32'd2);
      wait_idle("t3_idle", 100);

      // Test 4: word changes and REQ drop after LOAD are ignored
      REQ0  = 1'b1;
      WORD0 = 24'h48_22_C3;
      wait_go_low("t4_go_low", 20);
      chk("t4_word", {8'd0, ENG_SLAVE, ENG_POINTER, ENG_WDATA}, 32'h0048_22C3);
      WORD0  = 24'hFF_FF_FF;
      REQ0   = 1'b0;
      stable = 1'b1;
      n = 0;
      while (ACK0 !== 1'b1 && n < 50) begin
         tick();
         n++;
         if ({ENG_SLAVE, ENG_POINTER, ENG_WDATA} !== 24'h48_22_C3) stable = 1'b0;
      end
      chk("t4_word_stable", {31'd0, stable}, 32'd1);
      chk("t4_ack0",        {31'd0, ACK0},   32'd1);
      wait_idle("t4_idle", 100);
      repeat (5) tick();
      chk("t4_no_reserve", {31'd0, BUSY}, 32'd0);
      chk("t4_word_hold",  {8'd0, ENG_SLAVE, ENG_POINTER, ENG_WDATA}, 32'h0048_22C3);

      // Test 5: reset in GO_LOW, then req 0 wins contention
      REQ0 = 1'b1;
      wait_go_low("t5_go_low", 20);
      chk("t5_gnt_before", {31'd0, GNT_ID}, 32'd0);
      #2;
      RESET_N = 1'b0;
      #1;
      chk("t5_rst_go_n", {31'd0, ENG_GO_N}, 32'd1);
      chk("t5_rst_busy", {31'd0, BUSY},     32'd0);
      chk("t5_rst_ack",  {30'd0, ACK1, ACK0}, 32'd0);
      chk("t5_rst_word", {8'd0, ENG_SLAVE, ENG_POINTER, ENG_WDATA}, 32'd0);
      REQ1 = 1'b1;
      @(posedge CLK_400K);
      @(negedge CLK_400K);
      RESET_N = 1'b1;
      wait_go_low("t5_relaunch", 100);
      chk("t5_gnt_after", {31'd0, GNT_ID}, 32'd0);
      REQ0 = 1'b0;
      REQ1 = 1'b0;
      wait_ack("t5_ack_seen", 50, n);
      chk("t5_ack_id", {30'd0, ACK1, ACK0}, 32'd1);
      wait_idle("t5_idle", 100);

`ifdef I2C_ARB_TIMEOUT_EN
      // Test 6: watchdog fires TIMEOUT_CYC cycles after GO_LOW entry
      REQ0 = 1'b1;
      wait_go_low("t6_go_low", 20);
      eng_ok = 1'b0;
      repeat (TIMEOUT_CYC - 1) tick();
      chk("t6_err_early", {31'd0, ERR},  32'd0);
      chk("t6_ack_early", {31'd0, ACK0}, 32'd0);
      tick();
      chk("t6_err_set",   {31'd0, ERR},      32'd1);
      chk("t6_ack_to",    {31'd0, ACK0},     32'd1);
      chk("t6_go_n_to",   {31'd0, ENG_GO_N}, 32'd1);
      REQ0   = 1'b0;
      eng_ok = 1'b1;
      wait_idle("t6_idle", 100);
      REQ1 = 1'b1;
      wait_go_low("t6_good_go", 100);
      REQ1 = 1'b0;
      wait_ack("t6_good_ack", 50, n);
      chk("t6_good_ack_id", {30'd0, ACK1, ACK0}, 32'd2);
      chk("t6_err_sticky",  {31'd0, ERR}, 32'd1);
`else
      chk("t6_err_tied", {31'd0, ERR}, 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
